// File: rtl/vgafb_sfifo.sv
// Single-clock FIFO for the VGA framebuffer datapath: parametrised width/depth,
// optional first-word-fall-through output, level reporting and sticky error flags.
module vgafb_sfifo #(
   parameter int DATA_WIDTH    = 18,
   parameter int ADDRESS_WIDTH = 11,
   parameter int FWFT          = 1,
   parameter int AE_THRESH     = 4,
   parameter int AF_THRESH     = 2044
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic                     clear,
   input  logic                     wr_en,
   input  logic [DATA_WIDTH-1:0]    din,
   output logic                     full,
   output logic                     almost_full,
   input  logic                     rd_en,
   output logic [DATA_WIDTH-1:0]    dout,
   output logic                     empty,
   output logic                     almost_empty,
   output logic [ADDRESS_WIDTH:0]   level,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int DEPTH = 2 ** ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH:0] DEPTH_L = (ADDRESS_WIDTH+1)'(DEPTH);
   localparam logic [ADDRESS_WIDTH:0] AE_L    = (ADDRESS_WIDTH+1)'(AE_THRESH);
   localparam logic [ADDRESS_WIDTH:0] AF_L    = (ADDRESS_WIDTH+1)'(AF_THRESH);

   logic [DATA_WIDTH-1:0]    mem [DEPTH];

   logic [ADDRESS_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDRESS_WIDTH:0]   level_q, level_d;
   logic                     full_q, almost_full_q, empty_q, almost_empty_q;
   logic                     overflow_q, underflow_q;
   logic                     out_valid_q, out_valid_d;
   logic                     empty_d;
   logic [DATA_WIDTH-1:0]    dout_q;

   logic                     flush;
   logic                     wr_acc, rd_acc, fetch;

   always_comb begin
      flush       = sys_rst | clear;
      wr_acc      = wr_en & ~full_q & ~flush;
      rd_acc      = rd_en & ~empty_q & ~flush;
      level_d     = level_q + (ADDRESS_WIDTH+1)'(wr_acc) - (ADDRESS_WIDTH+1)'(rd_acc);
      fetch       = 1'b0;
      out_valid_d = 1'b0;
      empty_d     = (level_d == '0);
      if (FWFT != 0) begin
         // Words already in RAM but not yet in the output register are level minus
         // the output word; refill whenever the output register is free or consumed.
         fetch       = (level_q != (ADDRESS_WIDTH+1)'(out_valid_q)) & (~out_valid_q | rd_acc) & ~flush;
         out_valid_d = fetch | (out_valid_q & ~rd_acc);
         empty_d     = ~out_valid_d;
      end else begin
         fetch       = rd_acc;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (wr_acc) begin
         mem[wr_ptr_q] <= din;
      end
   end

   // Registered RAM read port doubles as the output register in both modes.
   always_ff @(posedge sys_clk) begin
      if (flush) begin
         dout_q <= '0;
      end else if (fetch) begin
         dout_q <= mem[rd_ptr_q];
      end
   end

   always_ff @(posedge sys_clk) begin
      if (flush) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         level_q        <= '0;
         full_q         <= 1'b0;
         almost_full_q  <= 1'b0;
         empty_q        <= 1'b1;
         almost_empty_q <= 1'b1;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
         out_valid_q    <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_q + ADDRESS_WIDTH'(wr_acc);
         rd_ptr_q       <= rd_ptr_q + ADDRESS_WIDTH'(fetch);
         level_q        <= level_d;
         full_q         <= (level_d == DEPTH_L);
         almost_full_q  <= (level_d >= AF_L);
         empty_q        <= empty_d;
         almost_empty_q <= (level_d <= AE_L);
         overflow_q     <= overflow_q | (wr_en & full_q);
         underflow_q    <= underflow_q | (rd_en & empty_q);
         out_valid_q    <= out_valid_d;
      end
   end

   assign full         = full_q;
   assign almost_full  = almost_full_q;
   assign empty        = empty_q;
   assign almost_empty = almost_empty_q;
   assign level        = level_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;
   assign dout         = dout_q;

endmodule

// File: doc/vgafb_sfifo.md
Name:
vgafb_sfifo

Overview:
Parametrised single-clock FIFO for the VGA framebuffer datapath. It sits between the FML burst fetcher and the pixel serializer when both run on the system clock. It generalises the fixed 18x2048 video FIFO: data width and depth are set by parameters, first-word-fall-through (FWFT) or standard read is selectable, and it adds level reporting, programmable almost-empty/almost-full thresholds and sticky overflow/underflow flags.

Parameters:
DATA_WIDTH, 18, word width in bits (1..72)
ADDRESS_WIDTH, 11, log2 of capacity; DEPTH = 2**ADDRESS_WIDTH words
FWFT, 1, 1 = first-word-fall-through, 0 = standard read
AE_THRESH, 4, almost_empty asserted while level <= AE_THRESH
AF_THRESH, 2044, almost_full asserted while level >= AF_THRESH

Ports:
sys_clk  in  1  clock; all logic on rising edge
sys_rst  in  1  reset; synchronous, active-high
clear  in  1  synchronous flush; same effect as sys_rst on FIFO state
wr_en  in  1  write request
din  in  DATA_WIDTH  write data
full  out  1  no space; level == DEPTH
almost_full  out  1  level >= AF_THRESH
rd_en  in  1  read request (FWFT: acknowledge of the word on dout)
dout  out  DATA_WIDTH  read data
empty  out  1  FWFT: dout invalid; standard: no word readable
almost_empty  out  1  level <= AE_THRESH
level  out  ADDRESS_WIDTH+1  words accepted and not yet read, 0..DEPTH
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Storage is a synchronous-read RAM of DEPTH x DATA_WIDTH. Write and read pointers are ADDRESS_WIDTH bits wide and wrap modulo DEPTH. Capacity is exactly DEPTH in both modes.
- Reset (sys_rst=1 at an edge): pointers = 0, level = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0, dout = 0, FWFT prefetch stage invalid. RAM contents are don't-care.
- clear has the same effect as reset and also clears overflow/underflow. sys_rst and clear take priority over wr_en/rd_en in the same cycle. Operations in flight are discarded.
- Write acceptance: wr_en & ~full, using the registered full in that cycle. A rejected write sets overflow and changes no other state.
- Read acceptance: rd_en & ~empty, using the registered empty. A rejected read sets underflow and changes no other state.
- Simultaneous read and write, both accepted: level is unchanged.
  - When full, the write is rejected even if a read is accepted in the same cycle; overflow is set.
  - When empty, the read is rejected (underflow is set) and the write is accepted.
- Level and flags are registered and computed from the next level:
  - level' = level + wr_acc - rd_acc
  - full' = (level' == DEPTH)
  - almost_full' = (level' >= AF_THRESH)
  - almost_empty' = (level' <= AE_THRESH)
- Standard mode (FWFT=0):
  - empty' = (level' == 0).
  - A read accepted at edge M presents data on dout after edge M+1 (1-cycle latency). dout holds its value otherwise.
  - A write at edge N into an empty FIFO deasserts empty after edge N+1.
- FWFT mode (FWFT=1):
  - A one-word output register is prefetched from the RAM. empty = ~(output register valid).
  - A write at edge N into an empty FIFO makes dout valid and deasserts empty after edge N+2.
  - level counts the word in flight, so level=1 while empty=1 is legal for one cycle.
  - A read accepted at edge M shows the next word on dout after edge M+1 if the RAM held at least 2 words at M. Otherwise empty rises after edge M+1 until the refill completes.
  - Back-to-back reads sustain 1 word/cycle with no bubbles while level >= 2.
- Word order is strictly preserved across pointer wrap-around.

Test Plan:
- Reset: assert sys_rst 2 cycles with random wr_en/rd_en/din -> empty=1, almost_empty=1, full=0, almost_full=0, level=0, overflow=0, underflow=0, dout=0.
- Fill: FWFT=1, write 0..2047 back-to-back, no reads -> almost_full rises after the edge accepting word 2044 (level=2044). full=1 and level=2048 after the 2048th write. A 2049th write is rejected, overflow=1, level stays 2048.
- FWFT latency and order: write 0x2A5A5 at edge N into an empty FIFO -> dout=0x2A5A5 and empty=0 after N+2. Then stream 3*DEPTH words with continuous rd_en -> output equals the input sequence with no gaps once level >= 2.
- Standard mode: FWFT=0, write 3 words, then rd_en at edge M -> first word on dout after M+1. A 4th read after 3 reads is rejected: underflow=1, dout unchanged.
- Simultaneous ops: at level=5 assert wr_en and rd_en for 10 cycles -> level stays 5 and almost_empty stays 0. At level=2048 with both asserted -> write rejected, level=2047, overflow=1.
- Clear mid-stream: at level=100 with overflow=1, assert clear together with wr_en=1 -> after the edge level=0, empty=1, overflow=0. The next write, 0x00001, is the first word read out.
